// File: rtl/ssemi_adc_pkg.sv
// ---------------------------------------------------------------------------
// ssemi_adc_pkg
// Shared constants for the ADC output path.
//   ADC_OUT_WIDTH : decimator output sample width (default FIFO data width)
//   OVF_CNT_WIDTH : default width of the saturating overflow counter
//   FIFO_*        : bit positions of the FIFO flags in the decimator status map
// ---------------------------------------------------------------------------
package ssemi_adc_pkg;

    localparam int ADC_OUT_WIDTH = 24;
    localparam int OVF_CNT_WIDTH = 16;

    // Status-map bit indices
    localparam int FIFO_EMPTY = 0;
    localparam int FIFO_FULL  = 1;
    localparam int FIFO_AFULL = 2;
    localparam int FIFO_OVF   = 3;

endpackage : ssemi_adc_pkg

// File: rtl/ssemi_adc_fifo_mem.sv
// ---------------------------------------------------------------------------
// ssemi_adc_fifo_mem
// DEPTH x DATA_WIDTH register file, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
//   i_clk   : clock, rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from storage)
// ---------------------------------------------------------------------------
module ssemi_adc_fifo_mem #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 16,
    parameter int ADDR       = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR-1:0]       i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR-1:0]       i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_r[i_raddr];

endmodule : ssemi_adc_fifo_mem

// File: rtl/ssemi_adc_output_fifo.sv
// ---------------------------------------------------------------------------
// ssemi_adc_output_fifo
// FWFT output buffer behind the ADC decimator. Samples arrive as valid-only
// pulses (no backpressure upstream) and leave over valid/ready. Reports fill
// level, watermark and sticky/saturating overflow statistics.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_enable           : accept incoming samples when high
//   i_flush            : discard all contents (wins over push/pop)
//   i_clear_status     : clear overflow flag/count (an overflow event wins)
//   i_valid, i_data    : decimator sample strobe and data
//   o_valid, o_data    : head entry, i_ready consumes it
//   o_level            : occupancy, o_empty/o_full/o_almost_full derived flags
//   o_overflow         : sticky "a sample was dropped"
//   o_overflow_count   : dropped-sample count, saturating
// ---------------------------------------------------------------------------
module ssemi_adc_output_fifo
    import ssemi_adc_pkg::*;
#(
    parameter int DATA_WIDTH   = ADC_OUT_WIDTH,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12,
    parameter int CNT_WIDTH    = OVF_CNT_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic                       i_flush,
    input  logic                       i_clear_status,
    input  logic                       i_valid,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic                       o_overflow,
    output logic [CNT_WIDTH-1:0]       o_overflow_count
);

    localparam int ADDR = $clog2(DEPTH);
    localparam int LW   = ADDR + 1;

    localparam logic [ADDR:0]          PTR_ZERO = {(ADDR+1){1'b0}};
    localparam logic [ADDR:0]          PTR_ONE  = {{ADDR{1'b0}}, 1'b1};
    localparam logic [LW-1:0]          LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0]          LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]          AFULL_LVL = LW'(AFULL_THRESH);
    localparam logic [CNT_WIDTH-1:0]   CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [ADDR:0]          wr_ptr_r, rd_ptr_r;
    logic [ADDR:0]          wr_ptr_next_s, rd_ptr_next_s;
    logic [LW-1:0]          level_r, level_next_s;
    logic                   empty_r, full_r, afull_r;
    logic                   ovf_r, ovf_next_s;
    logic [CNT_WIDTH-1:0]   ovf_cnt_r, ovf_cnt_next_s;
    logic                   push_s, pop_s, wr_en_s, ovf_event_s;
    logic [DATA_WIDTH-1:0]  rdata_s;

    assign push_s      = i_valid & i_enable & ~i_flush;
    assign pop_s       = ~empty_r & i_ready & ~i_flush;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign wr_en_s     = push_s & (~full_r | pop_s);
    assign ovf_event_s = push_s & full_r & ~pop_s;

    ssemi_adc_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR       (ADDR)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_en_s),
        .i_waddr (wr_ptr_r[ADDR-1:0]),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_r[ADDR-1:0]),
        .o_rdata (rdata_s)
    );

    // Next pointer and level state; flush overrides push and pop
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        level_next_s  = level_r;
        if (i_flush) begin
            wr_ptr_next_s = PTR_ZERO;
            rd_ptr_next_s = PTR_ZERO;
            level_next_s  = LVL_ZERO;
        end else begin
            wr_ptr_next_s = wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_next_s = pop_s   ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            level_next_s  = level_r + (wr_en_s ? LVL_ONE : LVL_ZERO)
                                    - (pop_s   ? LVL_ONE : LVL_ZERO);
        end
    end

    // Next overflow status; an overflow in the same cycle as clear wins
    always_comb begin
        ovf_next_s     = ovf_r;
        ovf_cnt_next_s = ovf_cnt_r;
        if (ovf_event_s) begin
            ovf_next_s = 1'b1;
            if (i_clear_status) begin
                ovf_cnt_next_s = CNT_ONE;
            end else if (ovf_cnt_r != CNT_MAX) begin
                ovf_cnt_next_s = ovf_cnt_r + CNT_ONE;
            end else begin
                ovf_cnt_next_s = ovf_cnt_r;
            end
        end else if (i_clear_status) begin
            ovf_next_s     = 1'b0;
            ovf_cnt_next_s = CNT_ZERO;
        end else begin
            ovf_next_s     = ovf_r;
            ovf_cnt_next_s = ovf_cnt_r;
        end
    end

    // State registers; flags are registered from the next pointers so they
    // stay consistent with o_valid every cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            level_r   <= LVL_ZERO;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            afull_r   <= 1'b0;
            ovf_r     <= 1'b0;
            ovf_cnt_r <= CNT_ZERO;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            level_r   <= level_next_s;
            empty_r   <= (wr_ptr_next_s == rd_ptr_next_s);
            full_r    <= (wr_ptr_next_s[ADDR] != rd_ptr_next_s[ADDR]) &&
                         (wr_ptr_next_s[ADDR-1:0] == rd_ptr_next_s[ADDR-1:0]);
            afull_r   <= (level_next_s >= AFULL_LVL);
            ovf_r     <= ovf_next_s;
            ovf_cnt_r <= ovf_cnt_next_s;
        end
    end

    assign o_valid          = ~empty_r;
    // Stale memory is masked so the data bus reads zero while empty.
    assign o_data           = empty_r ? {DATA_WIDTH{1'b0}} : rdata_s;
    assign o_level          = level_r;
    assign o_empty          = empty_r;
    assign o_full           = full_r;
    assign o_almost_full    = afull_r;
    assign o_overflow       = ovf_r;
    assign o_overflow_count = ovf_cnt_r;

endmodule : ssemi_adc_output_fifo

// File: tb/tb_ssemi_adc_output_fifo.sv
// ---------------------------------------------------------------------------
// tb_ssemi_adc_output_fifo
// Directed self-checking bench for ssemi_adc_output_fifo (DEPTH 16,
// AFULL_THRESH 12, CNT_WIDTH 4 so counter saturation is reachable).
// ---------------------------------------------------------------------------
module tb_ssemi_adc_output_fifo;

    localparam int DW = 24;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, enable, flush, clear_status, valid, ready;
    logic [DW-1:0] data;
    logic          o_valid, o_empty, o_full, o_afull, o_ovf;
    logic [DW-1:0] o_data;
    logic [4:0]    o_level;
    logic [CW-1:0] o_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ssemi_adc_output_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (16),
        .AFULL_THRESH (12),
        .CNT_WIDTH    (CW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_enable         (enable),
        .i_flush          (flush),
        .i_clear_status   (clear_status),
        .i_valid          (valid),
        .i_data           (data),
        .o_valid          (o_valid),
        .o_data           (o_data),
        .i_ready          (ready),
        .o_level          (o_level),
        .o_empty          (o_empty),
        .o_full           (o_full),
        .o_almost_full    (o_afull),
        .o_overflow       (o_ovf),
        .o_overflow_count (o_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_empty"}, o_empty, 1);
        chk({tag, "_full"},  o_full,  0);
        chk({tag, "_afull"}, o_afull, 0);
        chk({tag, "_level"}, o_level, 0);
        chk({tag, "_ovf"},   o_ovf,   0);
        chk({tag, "_cnt"},   o_cnt,   0);
        chk({tag, "_data"},  o_data,  0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0; clear_status = 1'b0;
        valid = 1'b0; ready = 1'b0; data = 24'h0;
        tick(); tick();
        rst_n = 1'b1;
        chk_reset_state("rst");

        // ---- Basic FWFT: 1..5 with ready high ----
        ready = 1'b1;
        valid = 1'b1; data = 24'h000001;
        #1;
        chk("fwft_no_bypass", o_valid, 0);
        for (int k = 1; k <= 5; k++) begin
            data = 24'(k);
            tick();
            chk("fwft_valid", o_valid, 1);
            chk("fwft_data",  o_data,  32'(k));
            chk("fwft_level", o_level, 1);
        end
        valid = 1'b0;
        tick();
        chk("fwft_drained_valid", o_valid, 0);
        chk("fwft_drained_empty", o_empty, 1);

        // ---- Fill and overflow: 18 pushes, ready low ----
        ready = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            data = 24'h100 + 24'(i);
            tick();
            chk("fill_level", o_level, (i + 1 > 16) ? 16 : i + 1);
            chk("fill_afull", o_afull, (i + 1 >= 12) ? 1 : 0);
            chk("fill_full",  o_full,  (i + 1 >= 16) ? 1 : 0);
        end
        chk("fill_ovf", o_ovf, 1);
        chk("fill_cnt", o_cnt, 2);
        chk("fill_head", o_data, 24'h100);

        // ---- Full with simultaneous push and pop ----
        data = 24'hABCDEF; ready = 1'b1;
        tick();
        chk("fullpp_level", o_level, 16);
        chk("fullpp_full",  o_full,  1);
        chk("fullpp_cnt",   o_cnt,   2);
        valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk("drain_data",  o_data,  (j < 15) ? 32'h101 + 32'(j) : 32'hABCDEF);
            chk("drain_level", o_level, 16 - j);
            tick();
        end
        chk("drain_empty", o_empty, 1);
        chk("drain_valid", o_valid, 0);

        // ---- Stall stability with 3 entries ----
        ready = 1'b0; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = 24'h31 + 24'(i);
            tick();
        end
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_data",  o_data,  24'h31);
            chk("stall_valid", o_valid, 1);
            chk("stall_level", o_level, 3);
        end
        ready = 1'b1;
        tick();
        chk("release_d1", o_data, 24'h32);
        tick();
        chk("release_d2", o_data, 24'h33);
        tick();
        chk("release_empty", o_empty, 1);

        // ---- Flush with a concurrent sample ----
        ready = 1'b0; valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data = 24'h50 + 24'(i);
            tick();
        end
        chk("preflush_level", o_level, 7);
        flush = 1'b1; data = 24'h77; ready = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0; ready = 1'b0;
        chk("flush_level", o_level, 0);
        chk("flush_valid", o_valid, 0);
        chk("flush_empty", o_empty, 1);
        chk("flush_data",  o_data,  0);
        chk("flush_cnt",   o_cnt,   2);
        chk("flush_ovf",   o_ovf,   1);

        // ---- Clear status colliding with an overflow ----
        valid = 1'b1;
        for (int i = 0; i < 19; i++) begin
            data = 24'h200 + 24'(i);
            tick();
        end
        chk("cnt_five", o_cnt, 5);
        clear_status = 1'b1;
        tick();
        chk("clr_ovf_flag", o_ovf, 1);
        chk("clr_ovf_cnt",  o_cnt, 1);
        valid = 1'b0;
        tick();
        clear_status = 1'b0;
        chk("clr_flag", o_ovf, 0);
        chk("clr_cnt",  o_cnt, 0);

        // ---- Enable low while full: silently ignored ----
        enable = 1'b0; valid = 1'b1;
        tick(); tick();
        chk("dis_ovf",   o_ovf,   0);
        chk("dis_cnt",   o_cnt,   0);
        chk("dis_level", o_level, 16);
        chk("dis_head",  o_data,  24'h200);
        enable = 1'b1;

        // ---- Counter saturation ----
        for (int i = 0; i < 20; i++) begin
            data = 24'h300 + 24'(i);
            tick();
            chk("sat_cnt", o_cnt, (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_head", o_data, 24'h200);

        // ---- Reset mid-stream ----
        rst_n = 1'b0; ready = 1'b1;
        tick();
        rst_n = 1'b1; valid = 1'b0; ready = 1'b0;
        chk_reset_state("midrst");
        valid = 1'b1; data = 24'h123;
        tick();
        valid = 1'b0;
        chk("post_rst_data",  o_data,  24'h123);
        chk("post_rst_level", o_level, 1);
        chk("post_rst_valid", o_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ssemi_adc_output_fifo
